// File: rtl/hamming_pkg.sv
// hamming_pkg: shared SECDED(22,16) widths, codeword type and data-position helpers
package hamming_pkg;
    localparam int DATA_W = 16;
    localparam int HAM_P = 5;
    localparam int CODE_W = 22;
    typedef logic [CODE_W-1:0] codeword_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [HAM_P-1:0] syn_t;
    // Data bits occupy every non-power-of-two position from 3 upward, in order.
    function automatic syn_t pos_of_data(input int k);
        syn_t r;
        int n;
        r = '0;
        n = 0;
        for (int i = 3; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == k) r = syn_t'(i);
                n++;
            end
        end
        return r;
    endfunction
    function automatic data_t extract_data(input codeword_t c);
        data_t d;
        for (int k = 0; k < DATA_W; k++) d[k] = c[pos_of_data(k)];
        return d;
    endfunction
endpackage

// File: rtl/hamming_secded_decoder_if.sv
// hamming_secded_decoder_if: codeword input and decoded-result output handshakes
interface hamming_secded_decoder_if;
    import hamming_pkg::*;
    logic      in_valid;
    logic      in_ready;
    codeword_t code_in;
    logic      out_valid;
    logic      out_ready;
    data_t     data_out;
    logic      sec_flag;
    logic      ded_flag;
    syn_t      err_pos;
    modport master (
        output in_valid, code_in, out_ready,
        input  in_ready, out_valid, data_out, sec_flag, ded_flag, err_pos
    );
    modport slave (
        input  in_valid, code_in, out_ready,
        output in_ready, out_valid, data_out, sec_flag, ded_flag, err_pos
    );
endinterface

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome (XOR of set-bit indices) and overall parity
module hamming_syndrome
    import hamming_pkg::*;
(
    input  codeword_t code_i,
    output syn_t      syn_o,
    output logic      par_o
);
    always_comb begin
        syn_o = '0;
        for (int i = 1; i < CODE_W; i++) if (code_i[i]) syn_o ^= syn_t'(i);
    end
    assign par_o = ^code_i;
endmodule

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: 2-stage SECDED decoder with saturating SEC/DED counters and sticky alarm
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_counts,
    hamming_secded_decoder_if.slave  bus,
    output logic [CNT_W-1:0]         sec_count,
    output logic [CNT_W-1:0]         ded_count,
    output logic                     ded_alarm
);
    logic             s1_valid_q, s1_par_q, out_valid_q, sec_q, ded_q, alarm_q, alarm_d;
    codeword_t        s1_code_q, fixed;
    syn_t             s1_syn_q, pos_q, syn;
    data_t            data_q;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
    logic             par, adv1, adv2, xfer, fix, sec_d, ded_d;

    hamming_syndrome u_syn (.code_i(bus.code_in), .syn_o(syn), .par_o(par));

    assign adv2          = ~out_valid_q | bus.out_ready;
    assign adv1          = ~s1_valid_q | adv2;
    assign xfer          = out_valid_q & bus.out_ready;
    assign bus.in_ready  = adv1 & reset;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.sec_flag  = sec_q;
    assign bus.ded_flag  = ded_q;
    assign bus.err_pos   = pos_q;
    assign sec_count     = sec_cnt_q;
    assign ded_count     = ded_cnt_q;
    assign ded_alarm     = alarm_q;

    // Syndromes 22..31 with odd parity point outside the codeword, so they are uncorrectable.
    always_comb begin
        sec_d     = s1_par_q && s1_syn_q < syn_t'(CODE_W);
        ded_d     = s1_syn_q != '0 && !sec_d;
        fix       = sec_d && s1_syn_q != '0;
        fixed     = s1_code_q ^ (fix ? (codeword_t'(1) << s1_syn_q) : '0);
        sec_cnt_d = clear_counts ? '0 : sec_cnt_q + CNT_W'(xfer && sec_q && !(&sec_cnt_q));
        ded_cnt_d = clear_counts ? '0 : ded_cnt_q + CNT_W'(xfer && ded_q && !(&ded_cnt_q));
        alarm_d   = clear_counts ? 1'b0 : alarm_q | (xfer & ded_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sec_q       <= 1'b0;
            ded_q       <= 1'b0;
            pos_q       <= '0;
            sec_cnt_q   <= '0;
            ded_cnt_q   <= '0;
            alarm_q     <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= bus.in_valid;
                s1_code_q  <= bus.code_in;
                s1_syn_q   <= syn;
                s1_par_q   <= par;
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                data_q      <= extract_data(fixed);
                sec_q       <= s1_valid_q & sec_d;
                ded_q       <= s1_valid_q & ded_d;
                pos_q       <= s1_syn_q;
            end
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
            alarm_q   <= alarm_d;
        end
    end
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder: directed vectors checked against a brute-force SECDED reference model
module tb_hamming_secded_decoder;
    logic       clk = 1'b0;
    logic       reset, clear_counts, ded_alarm;
    logic [7:0] sec_count, ded_count;
    int         tests = 0, fails = 0, delivered = 0;

    always #5 clk = ~clk;

    hamming_secded_decoder_if bus();

    hamming_secded_decoder #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clear_counts(clear_counts), .bus(bus),
        .sec_count(sec_count), .ded_count(ded_count), .ded_alarm(ded_alarm)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        sec;
        logic        ded;
        logic [4:0]  pos;
    } res_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference encoder built from the layout rules: data in non-power-of-two slots,
    // check bit 2^j = even parity over positions with bit j set, bit 0 = parity of 1..21.
    function automatic logic [21:0] m_enc(input logic [15:0] d);
        logic [21:0] c;
        logic        b;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p < 22; p++) if ((p & (p - 1)) != 0) begin c[p] = d[k]; k++; end
        for (int j = 0; j < 5; j++) begin
            b = 1'b0;
            for (int p = 1; p < 22; p++) if (((p >> j) & 1) == 1 && p != (1 << j)) b ^= c[p];
            c[1 << j] = b;
        end
        c[0] = ^c[21:1];
        return c;
    endfunction

    function automatic logic [15:0] m_ext(input logic [21:0] c);
        logic [15:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p < 22; p++) if ((p & (p - 1)) != 0) begin d[k] = c[p]; k++; end
        return d;
    endfunction

    // Decode by search: valid codeword -> clean; one flip away from a valid codeword -> SEC;
    // otherwise DED reporting the XOR-of-indices syndrome.
    function automatic res_t m_dec(input logic [21:0] c);
        res_t        r;
        logic [21:0] t;
        logic [4:0]  s;
        r = '0;
        if (m_enc(m_ext(c)) == c) begin r.d = m_ext(c); return r; end
        for (int j = 0; j < 22; j++) begin
            t = c ^ (22'(1) << j);
            if (m_enc(m_ext(t)) == t) begin
                r.d = m_ext(t); r.sec = 1'b1; r.pos = 5'(j);
                return r;
            end
        end
        s = '0;
        for (int i = 1; i < 22; i++) if (c[i]) s ^= 5'(i);
        r.d = m_ext(c); r.ded = 1'b1; r.pos = s;
        return r;
    endfunction

    res_t q[$];
    res_t cur, held, e;
    int   m_sec, m_ded;
    bit   m_alarm, hold;

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            m_sec = 0; m_ded = 0; m_alarm = 0; hold = 0;
        end else begin
            cur = '{d: bus.data_out, sec: bus.sec_flag, ded: bus.ded_flag, pos: bus.err_pos};
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2 || bus.out_ready));
            chk("sec_count", 32'(sec_count), 32'(m_sec));
            chk("ded_count", 32'(ded_count), 32'(m_ded));
            chk("ded_alarm", 32'(ded_alarm), 32'(m_alarm));
            if (hold) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_stable", 32'(cur), 32'(held));
            end
            if (bus.out_valid) begin
                if (q.size() == 0) chk("out_valid_without_pending_word", 32'(bus.out_valid), 0);
                else begin
                    chk("data_out", 32'(cur.d), 32'(q[0].d));
                    chk("sec_flag", 32'(cur.sec), 32'(q[0].sec));
                    chk("ded_flag", 32'(cur.ded), 32'(q[0].ded));
                    chk("err_pos", 32'(cur.pos), 32'(q[0].pos));
                end
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                e = q.pop_front();
                delivered++;
                if (e.sec && m_sec < 255) m_sec++;
                if (e.ded && m_ded < 255) m_ded++;
                if (e.ded) m_alarm = 1;
            end
            if (clear_counts) begin m_sec = 0; m_ded = 0; m_alarm = 0; end
            hold = bus.out_valid && !bus.out_ready;
            held = cur;
            if (bus.in_valid && bus.in_ready) q.push_back(m_dec(bus.code_in));
        end
    end

    task automatic send(input logic [21:0] c);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.code_in  = c;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        chk("accept_timeout", 32'(ok), 1);
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1; break; end
        end
    endtask

    task automatic one(input logic [21:0] c, input logic [15:0] d, input logic s, input logic x,
                       input logic [4:0] p, input string nm);
        bit ok;
        send(c);
        wait_out(ok);
        chk({nm, "_timeout"}, 32'(ok), 1);
        chk({nm, "_data"}, 32'(bus.data_out), 32'(d));
        chk({nm, "_sec"}, 32'(bus.sec_flag), 32'(s));
        chk({nm, "_ded"}, 32'(bus.ded_flag), 32'(x));
        chk({nm, "_pos"}, 32'(bus.err_pos), 32'(p));
        @(posedge clk) #1;
    endtask

    logic [21:0] bpw[6];
    bit          saw_stall, ok;
    int          sent, d0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 0; clear_counts = 0; bus.in_valid = 0; bus.code_in = '0; bus.out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_sec_count", 32'(sec_count), 0);
        chk("rst_ded_count", 32'(ded_count), 0);
        chk("rst_alarm", 32'(ded_alarm), 0);
        chk("model_enc_0001", 32'(m_enc(16'h0001)), 32'h00000F);
        chk("model_sec5_pos", 32'(m_dec(22'h000020).pos), 5);
        chk("model_ded22", 32'(m_dec(22'h010014).ded), 1);
        @(posedge clk) #1;
        reset = 1;

        one(22'h00000F, 16'h0001, 0, 0, 5'd0, "clean");
        one(22'h000020, 16'h0000, 1, 0, 5'd5, "sec5");
        @(negedge clk);
        chk("sec5_count", 32'(sec_count), 1);
        @(posedge clk) #1;
        one(22'h000001, 16'h0000, 1, 0, 5'd0, "sec0");
        one(22'h000006, 16'h0000, 0, 1, 5'd3, "ded12");
        @(negedge clk);
        chk("ded12_alarm", 32'(ded_alarm), 1);
        chk("ded12_count", 32'(ded_count), 1);
        @(posedge clk) #1;
        one(22'h010014, 16'h0000, 0, 1, 5'd22, "ded22");
        one(m_enc(16'hA5C3) ^ (22'(1) << 13), 16'hA5C3, 1, 0, 5'd13, "sec13");
        one(m_enc(16'hBEEF), 16'hBEEF, 0, 0, 5'd0, "clean_beef");

        for (int k = 0; k < 6; k++) bpw[k] = m_enc(16'h1000 + 16'(k * 257));
        bpw[3] = bpw[3] ^ (22'(1) << 9);
        bpw[4] = bpw[4] ^ 22'h000028;
        saw_stall = 0;
        d0 = delivered;
        fork
            begin for (int k = 0; k < 6; k++) send(bpw[k]); end
            begin bus.out_ready = 0; repeat (3) @(posedge clk); #1 bus.out_ready = 1; end
            begin for (int n = 0; n < 12; n++) begin @(negedge clk); if (!bus.in_ready) saw_stall = 1; end end
        join
        @(posedge clk) #1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_stall_seen", 32'(saw_stall), 1);
        chk("bp_delivered", 32'(delivered - d0), 6);
        @(posedge clk) #1;

        bus.in_valid = 1; bus.code_in = 22'h000020;
        sent = 0;
        for (int c = 0; c < 400 && sent < 260; c++) begin
            @(negedge clk);
            if (bus.in_ready) sent++;
        end
        @(posedge clk) #1;
        bus.in_valid = 0;
        chk("sat_sent", 32'(sent), 260);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sat_sec_count", 32'(sec_count), 255);
        @(posedge clk) #1;

        bus.out_ready = 0;
        send(22'h000020);
        wait_out(ok);
        chk("clr_timeout", 32'(ok), 1);
        @(posedge clk) #1;
        clear_counts = 1; bus.out_ready = 1;
        @(posedge clk) #1;
        clear_counts = 0;
        @(negedge clk);
        chk("clr_sec_count", 32'(sec_count), 0);
        chk("clr_alarm", 32'(ded_alarm), 0);
        @(posedge clk) #1;

        one(22'h000006, 16'h0000, 0, 1, 5'd3, "ded_pre");
        @(negedge clk);
        chk("pre_rst_ded_count", 32'(ded_count), 1);
        @(posedge clk) #1;
        bus.out_ready = 0;
        send(m_enc(16'h0F0F));
        send(m_enc(16'hF0F0));
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        chk("mid_rst_ded_count", 32'(ded_count), 0);
        chk("mid_rst_sec_count", 32'(sec_count), 0);
        chk("mid_rst_alarm", 32'(ded_alarm), 0);
        @(posedge clk) #1;
        reset = 1; bus.out_ready = 1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 32'(bus.out_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
